// File: rtl/lorenz_pixel_writer_if.sv
// rtl/lorenz_pixel_writer_if.sv - pixel write port between the Lorenz plotter and the frame buffer
//
// Purpose: carries one pixel write per accepted req/ack handshake.
// Signals:
//   wr_req    master->slave  write request, held until acknowledged
//   wr_x      master->slave  pixel column 0..639
//   wr_y      master->slave  pixel row 0..479
//   wr_color  master->slave  pixel colour
//   wr_ack    slave->master  write accepted in any cycle with wr_req && wr_ack
interface lorenz_pixel_writer_if;
  logic       wr_req;
  logic [9:0] wr_x;
  logic [8:0] wr_y;
  logic [7:0] wr_color;
  logic       wr_ack;

  modport master (output wr_req, output wr_x, output wr_y, output wr_color, input wr_ack);
  modport slave  (input wr_req, input wr_x, input wr_y, input wr_color, output wr_ack);
endinterface

// File: rtl/lorenz_pixel_writer.sv
// rtl/lorenz_pixel_writer.sv - plots the Lorenz trajectory into a 640x480 pixel buffer
//
// Purpose: owns the integrator time base (step pulse), decimates integrator steps,
// projects one coordinate pair of the 7.20 state to pixels, clips to the screen and
// writes the pixel over a req/ack port. Clears the screen after reset and on request.
// Ports:
//   clk_50      in   system clock
//   reset       in   synchronous, active-high
//   x, y, z     in   integrator state, signed 7.20
//   proj        in   projection (h,v): 0=(x,z) 1=(x,y) 2=(y,z) 3=(x,z)
//   color       in   colour of plotted points
//   clear_req   in   level request to clear the screen
//   step        out  one-cycle integrator advance pulse
//   busy_clear  out  high while the clear pass runs
//   pix         master side of the pixel write port
module lorenz_pixel_writer #(
  parameter int unsigned DECIM    = 1,
  parameter int unsigned SHIFT    = 17,
  parameter int          H_OFF    = 320,
  parameter int          V_OFF_Z  = 440,
  parameter int          V_OFF    = 240,
  parameter logic [7:0]  BG_COLOR = 8'h00
) (
  input  logic                clk_50,
  input  logic                reset,
  input  logic signed [26:0]  x,
  input  logic signed [26:0]  y,
  input  logic signed [26:0]  z,
  input  logic [1:0]          proj,
  input  logic [7:0]          color,
  input  logic                clear_req,
  output logic                step,
  output logic                busy_clear,
  lorenz_pixel_writer_if.master pix
);

  localparam logic [7:0]         DLAST    = 8'(DECIM - 1);
  localparam logic signed [26:0] H_OFF_S  = 27'(H_OFF);
  localparam logic signed [26:0] VOFF_Z_S = 27'(V_OFF_Z);
  localparam logic signed [26:0] VOFF_S   = 27'(V_OFF);

  typedef enum logic [2:0] {S_CLEAR, S_STEP, S_CAPTURE, S_COMPUTE, S_WRITE} state_t;

  state_t             state, state_n;
  logic [7:0]         dcnt, dcnt_n;
  logic signed [26:0] h_r, h_n, v_r, v_n;
  logic               v_is_z, v_is_z_n;
  logic               in_range, in_range_n;
  logic               wr_req_r, wr_req_n;
  logic [9:0]         wr_x_r, wr_x_n;
  logic [8:0]         wr_y_r, wr_y_n;
  logic [7:0]         wr_color_r, wr_color_n;
  logic               busy_r, busy_n;

  logic signed [26:0] voff, px, py;
  logic               pt_ok;

  // Projection is computed at full 27-bit width so far-off points cannot alias
  // back onto the screen before the range check.
  always_comb begin
    voff  = v_is_z ? VOFF_Z_S : VOFF_S;
    px    = H_OFF_S + (h_r >>> SHIFT);
    py    = voff - (v_r >>> SHIFT);
    pt_ok = (px >= 27'sd0) && (px <= 27'sd639) && (py >= 27'sd0) && (py <= 27'sd479);
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state      <= S_CLEAR;
      dcnt       <= '0;
      h_r        <= '0;
      v_r        <= '0;
      v_is_z     <= 1'b1;
      in_range   <= 1'b0;
      wr_req_r   <= 1'b0;
      wr_x_r     <= '0;
      wr_y_r     <= '0;
      wr_color_r <= BG_COLOR;
      busy_r     <= 1'b1;
    end else begin
      state      <= state_n;
      dcnt       <= dcnt_n;
      h_r        <= h_n;
      v_r        <= v_n;
      v_is_z     <= v_is_z_n;
      in_range   <= in_range_n;
      wr_req_r   <= wr_req_n;
      wr_x_r     <= wr_x_n;
      wr_y_r     <= wr_y_n;
      wr_color_r <= wr_color_n;
      busy_r     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    dcnt_n     = dcnt;
    h_n        = h_r;
    v_n        = v_r;
    v_is_z_n   = v_is_z;
    in_range_n = in_range;
    wr_req_n   = wr_req_r;
    wr_x_n     = wr_x_r;
    wr_y_n     = wr_y_r;
    wr_color_n = wr_color_r;
    busy_n     = busy_r;
    step       = 1'b0;

    unique case (state)
      S_CLEAR: begin
        // After reset wr_req is low for one cycle; the first request goes out here.
        if (!wr_req_r) begin
          wr_req_n = 1'b1;
        end else if (pix.wr_ack) begin
          if (wr_x_r != 10'd639) begin
            wr_x_n = wr_x_r + 10'd1;
          end else if (wr_y_r != 9'd479) begin
            wr_x_n = '0;
            wr_y_n = wr_y_r + 9'd1;
          end else begin
            wr_req_n = 1'b0;
            busy_n   = 1'b0;
            state_n  = S_STEP;
          end
        end
      end

      S_STEP: begin
        if (clear_req) begin
          wr_x_n     = '0;
          wr_y_n     = '0;
          wr_color_n = BG_COLOR;
          wr_req_n   = 1'b1;
          busy_n     = 1'b1;
          dcnt_n     = '0;
          state_n    = S_CLEAR;
        end else begin
          step    = 1'b1;
          state_n = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        unique case (proj)
          2'd1:    begin h_n = x; v_n = y; v_is_z_n = 1'b0; end
          2'd2:    begin h_n = y; v_n = z; v_is_z_n = 1'b1; end
          default: begin h_n = x; v_n = z; v_is_z_n = 1'b1; end
        endcase
        if (dcnt != DLAST) begin
          dcnt_n  = dcnt + 8'd1;
          state_n = S_STEP;
        end else begin
          dcnt_n  = '0;
          state_n = S_COMPUTE;
        end
      end

      S_COMPUTE: begin
        // Off-screen points leave the last written address untouched.
        in_range_n = pt_ok;
        wr_req_n   = pt_ok;
        if (pt_ok) begin
          wr_x_n     = px[9:0];
          wr_y_n     = py[8:0];
          wr_color_n = color;
        end
        state_n = S_WRITE;
      end

      S_WRITE: begin
        if (!in_range || pix.wr_ack) begin
          wr_req_n = 1'b0;
          state_n  = S_STEP;
        end
      end

      default: state_n = S_CLEAR;
    endcase
  end

  assign pix.wr_req   = wr_req_r;
  assign pix.wr_x     = wr_x_r;
  assign pix.wr_y     = wr_y_r;
  assign pix.wr_color = wr_color_r;
  assign busy_clear   = busy_r;

endmodule

// File: tb/tb_lorenz_pixel_writer.sv
// tb/tb_lorenz_pixel_writer.sv - self-checking bench for lorenz_pixel_writer
module tb_lorenz_pixel_writer;

  typedef struct {int x; int y; int z; int p; int c;} smp_t;
  typedef struct {logic [26:0] pt; int sn;} exp_t;

  logic clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  logic reset = 1'b1, reset_b = 1'b1;
  logic signed [26:0] xa = '0, ya = '0, za = '0, xb = '0, yb = '0, zb = '0;
  logic [1:0] proj_a = '0, proj_b = '0;
  logic [7:0] color_a = '0, color_b = '0;
  logic clear_req = 1'b0, clear_req_b = 1'b0;
  logic step_a, step_b, busy_a, busy_b;

  lorenz_pixel_writer_if pa ();
  lorenz_pixel_writer_if pb ();

  lorenz_pixel_writer #(.DECIM(1)) dut_a (
    .clk_50(clk_50), .reset(reset), .x(xa), .y(ya), .z(za), .proj(proj_a),
    .color(color_a), .clear_req(clear_req), .step(step_a), .busy_clear(busy_a), .pix(pa));

  lorenz_pixel_writer #(.DECIM(4)) dut_b (
    .clk_50(clk_50), .reset(reset_b), .x(xb), .y(yb), .z(zb), .proj(proj_b),
    .color(color_b), .clear_req(clear_req_b), .step(step_b), .busy_clear(busy_b), .pix(pb));

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // floor(a / 2^17): one screen pixel per 1/8 unit of 7.20
  function automatic int fdiv(input int a);
    int d;
    d = 1 << 17;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  // Returns {valid, x[9:0], y[8:0], color[7:0]} for one sample.
  function automatic logic [27:0] model_pt(input int sx, input int sy, input int sz,
                                           input int p, input int col);
    int h, v, voff, px, py;
    case (p)
      1:       begin h = sx; v = sy; voff = 240; end
      2:       begin h = sy; v = sz; voff = 440; end
      default: begin h = sx; v = sz; voff = 440; end
    endcase
    px = 320 + fdiv(h);
    py = voff - fdiv(v);
    if (px < 0 || px > 639 || py < 0 || py > 479) return '0;
    return {1'b1, 10'(px), 9'(py), 8'(col)};
  endfunction

  function automatic smp_t rnd_smp();
    smp_t s;
    s.x = int'($urandom_range(0, 100 << 20)) - (40 << 20);
    s.y = int'($urandom_range(0, 100 << 20)) - (40 << 20);
    s.z = int'($urandom_range(0, 100 << 20)) - (40 << 20);
    s.p = int'($urandom_range(0, 3));
    s.c = int'($urandom_range(1, 255));
    return s;
  endfunction

  smp_t dq_a[$];
  exp_t exp_a[$], exp_b[$];
  smp_t sa, sb;
  exp_t ema, emb;
  logic [27:0] ea, eb;

  int  cyc = 0;
  int  steps_a = 0, nsteps_b = 0;
  logic step_seen_a = 0, step_seen_b = 0;
  logic ack_rand_a = 0, ack_force_a = 1, ack_b = 1;

  always @(posedge clk_50) cyc <= cyc + 1;

  // Drive phase: integrator stubs advance and acks change just after the edge.
  always begin
    @(posedge clk_50);
    #1;
    if (reset_b) begin
      exp_b.delete();
      nsteps_b    = 0;
      step_seen_b = 0;
    end
    if (step_seen_a) begin
      if (dq_a.size() > 0) sa = dq_a.pop_front();
      else sa = rnd_smp();
      xa = 27'(sa.x); ya = 27'(sa.y); za = 27'(sa.z);
      proj_a = 2'(sa.p); color_a = 8'(sa.c);
      steps_a++;
      ea = model_pt(sa.x, sa.y, sa.z, sa.p, sa.c);
      if (ea[27]) exp_a.push_back('{ea[26:0], steps_a});
      step_seen_a = 0;
    end
    if (step_seen_b) begin
      sb = rnd_smp();
      xb = 27'(sb.x); yb = 27'(sb.y); zb = 27'(sb.z);
      proj_b = 2'(sb.p); color_b = 8'(sb.c);
      nsteps_b++;
      if (nsteps_b % 4 == 0) begin
        eb = model_pt(sb.x, sb.y, sb.z, sb.p, sb.c);
        if (eb[27]) exp_b.push_back('{eb[26:0], nsteps_b});
      end
      step_seen_b = 0;
    end
    pa.wr_ack = ack_rand_a ? ($urandom_range(0, 3) != 0) : ack_force_a;
    pb.wr_ack = ack_b;
  end

  // Monitor for instance A (DECIM=1)
  int   clr_idx = 0, wr_cnt_a = 0, run_a = 0, last_run_a = 0, last_step_a = 0, ack_cyc_a = 0;
  logic prev_busy_a = 0, prev_req_a = 0, prev_pend_a = 0, clr_last = 0, pend_step_a = 0;
  logic [27:0] prev_bus_a = '0;
  logic [9:0]  first_x = '0;
  logic [8:0]  first_y = '0;

  always @(negedge clk_50) begin
    if (!reset) begin
      if (busy_a && !prev_busy_a) begin
        clr_idx = 0;
        check("clr_start_exp_empty", exp_a.size(), 0);
      end
      if (clr_last) begin
        check("busy_fall", busy_a, 0);
        check("clear_count", clr_idx, 307200);
        clr_last = 0;
      end
      if (busy_a) check("step_in_clear", step_a, 0);
      if (prev_pend_a)
        check("hold", {pa.wr_req, pa.wr_x, pa.wr_y, pa.wr_color}, prev_bus_a);
      if (pa.wr_req && !busy_a) begin
        check("step_in_write", step_a, 0);
        run_a++;
        if (!prev_req_a) check("latency", cyc - last_step_a, 3);
      end
      if (step_a) begin
        if (pend_step_a) check("step_after_ack", cyc - ack_cyc_a, 1);
        pend_step_a = 0;
        last_step_a = cyc;
        step_seen_a = 1;
      end
      if (pa.wr_req && pa.wr_ack) begin
        if (busy_a) begin
          check("clr_addr", {pa.wr_y, pa.wr_x, pa.wr_color},
                {9'(clr_idx / 640), 10'(clr_idx % 640), 8'h00});
          clr_idx++;
          if (clr_idx == 307200) clr_last = 1;
        end else begin
          check("exp_a_nonempty", exp_a.size() > 0, 1);
          if (exp_a.size() > 0) begin
            ema = exp_a.pop_front();
            check("point_a", {pa.wr_x, pa.wr_y, pa.wr_color}, ema.pt);
          end
          if (wr_cnt_a == 0) begin first_x = pa.wr_x; first_y = pa.wr_y; end
          wr_cnt_a++;
          last_run_a = run_a;
          run_a = 0;
          if (!clear_req) begin pend_step_a = 1; ack_cyc_a = cyc; end
        end
      end
      prev_pend_a = pa.wr_req && !pa.wr_ack;
      prev_bus_a  = {pa.wr_req, pa.wr_x, pa.wr_y, pa.wr_color};
      prev_req_a  = pa.wr_req;
      prev_busy_a = busy_a;
    end
  end

  // Monitor for instance B (DECIM=4)
  int wr_cnt_b = 0, last_step_b = 0;

  always @(negedge clk_50) begin
    if (!reset_b) begin
      if (step_b) begin
        if (busy_b) check("b_step_in_clear", step_b, 0);
        if (nsteps_b % 4 != 0) check("b_step_gap", cyc - last_step_b, 2);
        last_step_b = cyc;
        step_seen_b = 1;
      end
      if (pb.wr_req && pb.wr_ack && !busy_b) begin
        check("exp_b_nonempty", exp_b.size() > 0, 1);
        if (exp_b.size() > 0) begin
          emb = exp_b.pop_front();
          check("point_b", {pb.wr_x, pb.wr_y, pb.wr_color}, emb.pt);
          check("b_sample_no", nsteps_b, emb.sn);
        end
        wr_cnt_b++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_50);
    #2;
  endtask

  int n0, s0;

  initial begin
    dq_a.push_back('{0, 0, 25 << 20, 0, 8'h5a});
    dq_a.push_back('{-(50 << 20), 0, 25 << 20, 0, 8'h33});

    repeat (3) tick();
    check("rst_step", step_a, 0);
    check("rst_wr_req", pa.wr_req, 0);
    check("rst_wr_x", pa.wr_x, 0);
    check("rst_wr_y", pa.wr_y, 0);
    check("rst_wr_color", pa.wr_color, 0);
    check("rst_busy", busy_a, 1);
    reset = 0;
    reset_b = 0;

    // full clear with ack tied high
    for (int i = 0; i < 310000 && (busy_a || cyc < 10); i++) tick();
    check("clear_done_a", busy_a, 0);
    check("clear_writes", clr_idx, 307200);

    // on-screen point then off-screen point
    for (int i = 0; i < 50 && wr_cnt_a < 1; i++) tick();
    check("t2_write_seen", wr_cnt_a, 1);
    check("t2_x", first_x, 320);
    check("t2_y", first_y, 240);
    for (int i = 0; i < 50 && steps_a < 3; i++) tick();
    check("t3_step_seen", steps_a, 3);
    check("t3_no_write", wr_cnt_a, 1);
    check("t3_x_kept", pa.wr_x, 320);
    check("t3_y_kept", pa.wr_y, 240);

    // random points with random backpressure
    ack_rand_a = 1;
    for (int i = 0; i < 5000 && wr_cnt_a < 40; i++) tick();
    check("rand_writes_a", wr_cnt_a >= 40, 1);

    // 5-cycle stall during a write
    ack_rand_a = 0;
    ack_force_a = 0;
    for (int i = 0; i < 50 && pa.wr_req; i++) tick();
    for (int i = 0; i < 100 && !(pa.wr_req && !busy_a); i++) tick();
    check("t5_req_seen", pa.wr_req, 1);
    n0 = wr_cnt_a;
    s0 = steps_a;
    repeat (4) tick();
    ack_force_a = 1;
    for (int i = 0; i < 10 && wr_cnt_a == n0; i++) tick();
    check("t5_accepted", wr_cnt_a, n0 + 1);
    check("t5_run_len", last_run_a, 6);
    check("t5_no_step", steps_a, s0);

    // clear request while a write is pending
    ack_force_a = 0;
    for (int i = 0; i < 50 && pa.wr_req; i++) tick();
    for (int i = 0; i < 100 && !(pa.wr_req && !busy_a); i++) tick();
    n0 = wr_cnt_a;
    clear_req = 1;
    repeat (3) tick();
    check("t6_busy_wait", busy_a, 0);
    check("t6_req_held", pa.wr_req, 1);
    ack_force_a = 1;
    for (int i = 0; i < 10 && !busy_a; i++) tick();
    check("t6_clear_started", busy_a, 1);
    check("t6_write_done", wr_cnt_a, n0 + 1);
    clear_req = 0;
    ack_rand_a = 1;
    repeat (200) tick();
    check("t6_clear_progress", clr_idx > 50, 1);

    // DECIM=4 instance: writes so far, then reset during a pending write
    check("t4_b_writes", wr_cnt_b >= 5, 1);
    ack_b = 0;
    for (int i = 0; i < 200 && !(pb.wr_req && !busy_b); i++) tick();
    check("t6b_req_seen", pb.wr_req, 1);
    tick();
    reset_b = 1;
    tick();
    check("t6b_req_drop", pb.wr_req, 0);
    check("t6b_busy", busy_b, 1);
    check("t6b_addr", {pb.wr_x, pb.wr_y}, 0);
    reset_b = 0;
    ack_b = 1;
    for (int i = 0; i < 10 && !pb.wr_req; i++) tick();
    check("t6b_restart_req", pb.wr_req, 1);
    check("t6b_restart_addr", {pb.wr_x, pb.wr_y, pb.wr_color}, 0);
    check("t6b_no_step", step_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
